// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD collector: FSM states, digit width
// and the active-high {a,b,c,d,e,f,g} 7-segment patterns.
package bcd_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   localparam logic [6:0] SEG_0    = 7'b1111110;
   localparam logic [6:0] SEG_1    = 7'b0110000;
   localparam logic [6:0] SEG_2    = 7'b1101101;
   localparam logic [6:0] SEG_3    = 7'b1111001;
   localparam logic [6:0] SEG_4    = 7'b0110011;
   localparam logic [6:0] SEG_5    = 7'b1011011;
   localparam logic [6:0] SEG_6    = 7'b1011111;
   localparam logic [6:0] SEG_7    = 7'b1110000;
   localparam logic [6:0] SEG_8    = 7'b1111111;
   localparam logic [6:0] SEG_9    = 7'b1111011;
   localparam logic [6:0] SEG_DASH = 7'b0000001;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational nibble to 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] nibble_i,
   output logic [6:0]         seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      case (nibble_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_serial_collector.sv
// Reassembles LSB-first serial BCD digits, flags non-BCD codes and framing
// aborts, keeps a history of valid digits and drives a 7-segment pattern.
module bcd_serial_collector
   import bcd_pkg::*;
#(
   parameter int DIGITS = 2
)(
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic                    Bit_In,
   input  logic                    Bit_Valid,
   input  logic                    First,
   output logic [DIGIT_W-1:0]      Digit,
   output logic                    Digit_Valid,
   output logic                    Digit_Err,
   output logic                    Frame_Err,
   output logic [6:0]              Seg,
   output logic [DIGIT_W*DIGITS-1:0] Bcd_Word
);

   state_e                      state_q;
   logic [1:0]                  cnt_q;
   logic [DIGIT_W-1:0]          sr_q;
   logic [DIGIT_W-1:0]          digit_q;
   logic                        digit_valid_q;
   logic                        digit_err_q;
   logic                        frame_err_q;
   logic [6:0]                  seg_q;
   logic [DIGIT_W*DIGITS-1:0]   word_q;

   logic [DIGIT_W-1:0]          nibble_d;
   logic [6:0]                  seg_d;
   logic [DIGIT_W*DIGITS-1:0]   word_d;

   // Nibble as it will be once the bit currently on Bit_In lands in bit 3.
   assign nibble_d = {Bit_In, sr_q[2:0]};

   bcd_to_seg u_seg (
      .nibble_i (nibble_d),
      .seg_o    (seg_d)
   );

   generate
      if (DIGITS == 1) begin : gen_single
         assign word_d = nibble_d;
      end else begin : gen_multi
         assign word_d = {word_q[DIGIT_W*DIGITS-5:0], nibble_d};
      end
   endgenerate

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q       <= IDLE;
         cnt_q         <= 2'd0;
         sr_q          <= '0;
         digit_q       <= '0;
         digit_valid_q <= 1'b0;
         digit_err_q   <= 1'b0;
         frame_err_q   <= 1'b0;
         seg_q         <= SEG_0;
         word_q        <= '0;
      end else begin
         digit_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (Bit_Valid && First) begin
                  sr_q    <= {3'b000, Bit_In};
                  cnt_q   <= 2'd1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (Bit_Valid) begin
                  if (First) begin
                     // Early First: drop the partial digit and restart on this bit.
                     sr_q        <= {3'b000, Bit_In};
                     cnt_q       <= 2'd1;
                     frame_err_q <= 1'b1;
                  end else if (cnt_q == 2'd3) begin
                     sr_q          <= nibble_d;
                     digit_q       <= nibble_d;
                     digit_err_q   <= (nibble_d > 4'd9);
                     seg_q         <= seg_d;
                     digit_valid_q <= 1'b1;
                     if (nibble_d <= 4'd9) begin
                        word_q <= word_d;
                     end
                     cnt_q   <= 2'd0;
                     state_q <= IDLE;
                  end else begin
                     sr_q[cnt_q] <= Bit_In;
                     cnt_q       <= cnt_q + 2'd1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= 2'd0;
            end
         endcase
      end
   end

   assign Digit       = digit_q;
   assign Digit_Valid = digit_valid_q;
   assign Digit_Err   = digit_err_q;
   assign Frame_Err   = frame_err_q;
   assign Seg         = seg_q;
   assign Bcd_Word    = word_q;

endmodule

// File: tb/tb_bcd_serial_collector.sv
// Bench for bcd_serial_collector: table-driven digits, hand-built corner
// sequences and randomized traffic against a queue-based reference model.
module tb_bcd_serial_collector;

   localparam int DIGITS = 2;
   localparam int WW     = 4 * DIGITS;

   logic          Clk = 1'b0;
   logic          Rst = 1'b0;
   logic          Bit_In = 1'b0;
   logic          Bit_Valid = 1'b0;
   logic          First = 1'b0;
   logic [3:0]    Digit;
   logic          Digit_Valid;
   logic          Digit_Err;
   logic          Frame_Err;
   logic [6:0]    Seg;
   logic [WW-1:0] Bcd_Word;

   bcd_serial_collector #(.DIGITS(DIGITS)) dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .Bit_In      (Bit_In),
      .Bit_Valid   (Bit_Valid),
      .First       (First),
      .Digit       (Digit),
      .Digit_Valid (Digit_Valid),
      .Digit_Err   (Digit_Err),
      .Frame_Err   (Frame_Err),
      .Seg         (Seg),
      .Bcd_Word    (Bcd_Word)
   );

   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: bits of the digit in progress, plus expected outputs.
   bit         part_q[$];
   logic [6:0] seg_tab [16];
   logic [3:0] m_digit;
   logic       m_dv, m_err, m_fe;
   logic [6:0] m_seg;
   longint     m_word;

   typedef struct {
      logic [3:0]    nib;
      int            gap;
      logic          err;
      logic [6:0]    seg;
      logic [WW-1:0] word;
   } vec_t;
   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      part_q.delete();
      m_digit = 4'd0; m_dv = 1'b0; m_err = 1'b0; m_fe = 1'b0;
      m_seg = 7'b1111110; m_word = 0;
   endtask

   task automatic model_edge(input bit bv, input bit f, input bit b);
      int d;
      m_dv = 1'b0;
      m_fe = 1'b0;
      if (!bv) return;
      if (f) begin
         if (part_q.size() > 0) m_fe = 1'b1;
         part_q.delete();
         part_q.push_back(b);
      end else if (part_q.size() > 0) begin
         part_q.push_back(b);
      end
      if (part_q.size() == 4) begin
         d = part_q[0] + 2 * part_q[1] + 4 * part_q[2] + 8 * part_q[3];
         part_q.delete();
         m_digit = 4'(d);
         m_err   = (d > 9);
         m_seg   = seg_tab[d];
         m_dv    = 1'b1;
         if (d <= 9) m_word = (m_word * 16 + d) % (64'd1 << WW);
      end
   endtask

   task automatic check_all(input string name);
      n_cmp++;
      if (Digit !== m_digit || Digit_Valid !== m_dv || Digit_Err !== m_err ||
          Frame_Err !== m_fe || Seg !== m_seg || Bcd_Word !== WW'(m_word)) begin
         n_bad++;
         $display("FAIL %s: got dig=%h dv=%b err=%b fe=%b seg=%b word=%h expected dig=%h dv=%b err=%b fe=%b seg=%b word=%h at %0t",
                  name, Digit, Digit_Valid, Digit_Err, Frame_Err, Seg, Bcd_Word,
                  m_digit, m_dv, m_err, m_fe, m_seg, WW'(m_word), $time);
      end
   endtask

   task automatic step(input bit bv, input bit f, input bit b, input string name);
      Bit_Valid = bv; First = f; Bit_In = b;
      @(posedge Clk);
      #1;
      model_edge(bv, f, b);
      check_all(name);
   endtask

   // Sends one digit LSB first; 'gap' idle cycles are inserted between bits 1 and 2.
   task automatic send_digit(input logic [3:0] nib, input int gap, input string name);
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin
            for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), name);
         end
         step(1'b1, (i == 0), nib[i], name);
      end
   endtask

   initial begin
      seg_tab[0] = 7'b1111110; seg_tab[1] = 7'b0110000; seg_tab[2] = 7'b1101101;
      seg_tab[3] = 7'b1111001; seg_tab[4] = 7'b0110011; seg_tab[5] = 7'b1011011;
      seg_tab[6] = 7'b1011111; seg_tab[7] = 7'b1110000; seg_tab[8] = 7'b1111111;
      seg_tab[9] = 7'b1111011;
      for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0000001;

      vecs[0] = '{4'd5,  0, 1'b0, 7'b1011011, 8'h05};
      vecs[1] = '{4'd3,  0, 1'b0, 7'b1111001, 8'h53};
      vecs[2] = '{4'd7,  0, 1'b0, 7'b1110000, 8'h37};
      vecs[3] = '{4'd12, 0, 1'b1, 7'b0000001, 8'h37};
      vecs[4] = '{4'd8,  2, 1'b0, 7'b1111111, 8'h78};
      vecs[5] = '{4'd9,  1, 1'b0, 7'b1111011, 8'h89};
      vecs[6] = '{4'd15, 0, 1'b1, 7'b0000001, 8'h89};
      vecs[7] = '{4'd0,  3, 1'b0, 7'b1111110, 8'h90};

      model_reset();
      repeat (3) @(posedge Clk);
      #1;
      chk("reset_digit", 32'(Digit), 32'h0);
      chk("reset_seg", 32'(Seg), 32'b1111110);
      chk("reset_word", 32'(Bcd_Word), 32'h0);
      chk("reset_pulses", {30'd0, Digit_Valid, Frame_Err}, 32'h0);
      @(negedge Clk);
      Rst = 1'b1;

      step(1'b1, 1'b0, 1'b1, "idle_no_first");
      step(1'b0, 1'b1, 1'b1, "idle_first_no_valid");

      for (int v = 0; v < 8; v++) begin
         send_digit(vecs[v].nib, vecs[v].gap, "table_bits");
         chk("tbl_valid", 32'(Digit_Valid), 32'h1);
         chk("tbl_digit", 32'(Digit), 32'(vecs[v].nib));
         chk("tbl_err", 32'(Digit_Err), 32'(vecs[v].err));
         chk("tbl_seg", 32'(Seg), 32'(vecs[v].seg));
         chk("tbl_word", 32'(Bcd_Word), 32'(vecs[v].word));
         $display("vector %0d: nib=%0d gap=%0d -> digit=%0d err=%b seg=%b word=%h",
                  v, vecs[v].nib, vecs[v].gap, Digit, Digit_Err, Seg, Bcd_Word);
      end
      step(1'b0, 1'b0, 1'b0, "after_table");
      chk("valid_one_cycle", 32'(Digit_Valid), 32'h0);

      // Early First after two bits, then a full 9.
      step(1'b1, 1'b1, 1'b1, "frame_b0");
      step(1'b1, 1'b0, 1'b1, "frame_b1");
      step(1'b1, 1'b1, 1'b1, "frame_restart");
      chk("frame_err_pulse", 32'(Frame_Err), 32'h1);
      chk("frame_no_valid", 32'(Digit_Valid), 32'h0);
      step(1'b1, 1'b0, 1'b0, "frame_9_b1");
      chk("frame_err_clear", 32'(Frame_Err), 32'h0);
      step(1'b1, 1'b0, 1'b0, "frame_9_b2");
      step(1'b1, 1'b0, 1'b1, "frame_9_b3");
      chk("frame_digit9", 32'(Digit), 32'h9);
      chk("frame_valid9", 32'(Digit_Valid), 32'h1);
      $display("frame abort: digit=%0d word=%h", Digit, Bcd_Word);

      // Asynchronous reset mid-cycle after three bits of a digit.
      step(1'b1, 1'b1, 1'b0, "rst_b0");
      step(1'b1, 1'b0, 1'b1, "rst_b1");
      step(1'b1, 1'b0, 1'b1, "rst_b2");
      #2 Rst = 1'b0;
      #1;
      model_reset();
      chk("async_digit", 32'(Digit), 32'h0);
      chk("async_seg", 32'(Seg), 32'b1111110);
      chk("async_word", 32'(Bcd_Word), 32'h0);
      @(negedge Clk);
      Rst = 1'b1;
      step(1'b1, 1'b0, 1'b1, "rst_orphan_bit");
      chk("rst_no_pulse", 32'(Digit_Valid), 32'h0);
      send_digit(4'd4, 0, "rst_digit4");
      chk("rst_digit4", 32'(Digit), 32'h4);
      chk("rst_word04", 32'(Bcd_Word), 32'h04);
      $display("reset recovery: digit=%0d word=%h", Digit, Bcd_Word);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
              1'($urandom_range(0, 1)), "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
